// File: rtl/fp_norm_pkg.sv
// rtl/fp_norm_pkg.sv - shared types and helpers for the FADD/FSUB normaliser
package fp_norm_pkg;

  typedef enum logic [2:0] {
    CARRY,
    ZERO,
    SUBN,
    NORM,
    TINY
  } norm_case_e;

  // Control half of the stage-1 payload; the parametric mantissa/exponent live beside it.
  typedef struct packed {
    norm_case_e ncase;
    logic       sign;
    logic       zero;
    logic       tiny;
    logic       ovf;
    logic       sticky_lo;
  } s1_payload_t;

  function automatic int unsigned exp_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter, binary tree over a heap-indexed node array
module fp_lzc #(
  parameter int W     = 48,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     data_i,
  output logic [CNT_W-1:0] count_o,
  output logic             all_zero_o
);

  localparam int P  = 1 << $clog2(W);
  localparam int CW = $clog2(P) + 1;

  logic [P-1:0]  padded;
  logic          nv [1:2*P-1];
  logic [CW-1:0] nc [1:2*P-1];

  // Padding below the LSB with ones keeps counts of non-zero inputs unchanged.
  generate
    if (P > W) begin : g_pad
      assign padded = {data_i, {(P - W){1'b1}}};
    end else begin : g_nopad
      assign padded = data_i;
    end
  endgenerate

  genvar k;
  generate
    for (k = 0; k < P; k++) begin : g_leaf
      assign nv[P + k] = padded[P - 1 - k];
      assign nc[P + k] = '0;
    end
    for (k = 1; k < P; k++) begin : g_node
      localparam int D    = $clog2(k + 1) - 1;
      localparam int HALF = P >> (D + 1);
      assign nv[k] = nv[2*k] | nv[2*k + 1];
      assign nc[k] = nv[2*k] ? nc[2*k] : (CW'(HALF) + nc[2*k + 1]);
    end
  endgenerate

  assign all_zero_o = ~|data_i;
  assign count_o    = all_zero_o ? CNT_W'(W) : CNT_W'(nc[1]);

endmodule

// File: rtl/fp_normalize_pipe.sv
// rtl/fp_normalize_pipe.sv - 2-stage normaliser between mantissa adder and rounder
// Stage 1 classifies the sum and picks shift/exponent; stage 2 shifts and extracts fraction and G/R/S.
module fp_normalize_pipe
  import fp_norm_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int SUM_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_in,
  input  logic             eff_sub,
  input  logic             carry_in,
  input  logic [SUM_W-1:0] mant_in,
  input  logic [EXP_W-1:0] exp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_out,
  output logic [EXP_W-1:0] exp_out,
  output logic [MAN_W-1:0] mant_out,
  output logic             guard,
  output logic             round_b,
  output logic             sticky,
  output logic             zero_out,
  output logic             tiny_out,
  output logic             ovf_out
);

  localparam int LZC_W = $clog2(SUM_W + 1);
  localparam int STK_W = SUM_W - MAN_W - 3;
  localparam logic [EXP_W:0]   EXP_ONES = (EXP_W + 1)'(exp_max(EXP_W));
  localparam logic [EXP_W:0]   EXP_INC1 = (EXP_W + 1)'(1);
  localparam logic [EXP_W-1:0] EXP_DEC1 = EXP_W'(1);

  logic             en1, en2;
  logic [LZC_W-1:0] lz;
  logic             mant_zero;

  logic             s1_valid_q;
  s1_payload_t      s1_pl_q, s1_pl_d;
  logic [SUM_W-1:0] s1_mant_q;
  logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
  logic [LZC_W-1:0] s1_lsh_q, s1_lsh_d;
  logic [EXP_W:0]   exp_inc;

  logic             s2_valid_q;
  logic             sign_q, guard_q, round_q, sticky_q, zero_q, tiny_q, ovf_q;
  logic             guard_d, round_d, sticky_d;
  logic [EXP_W-1:0] exp_q;
  logic [MAN_W-1:0] mant_q, mant_d;
  logic [SUM_W-2:0] shifted;

  assign en2      = ~s2_valid_q | out_ready;
  assign en1      = ~s1_valid_q | en2;
  assign in_ready = en1;

  fp_lzc #(.W(SUM_W), .CNT_W(LZC_W)) u_lzc (
    .data_i     (mant_in),
    .count_o    (lz),
    .all_zero_o (mant_zero)
  );

  always_comb begin
    s1_pl_d       = '0;
    s1_pl_d.ncase = NORM;
    s1_pl_d.sign  = sign_in;
    s1_exp_d      = '0;
    s1_lsh_d      = '0;
    exp_inc       = {1'b0, exp_in} + EXP_INC1;
    if (carry_in) begin
      s1_pl_d.ncase     = CARRY;
      s1_pl_d.sticky_lo = mant_in[0];
      if (exp_inc >= EXP_ONES) begin
        s1_pl_d.ovf       = 1'b1;
        s1_pl_d.sticky_lo = 1'b0;
        s1_exp_d          = EXP_ONES[EXP_W-1:0];
      end else begin
        s1_exp_d = exp_inc[EXP_W-1:0];
      end
    end else if (mant_zero) begin
      s1_pl_d.ncase = ZERO;
      s1_pl_d.zero  = 1'b1;
      s1_pl_d.sign  = sign_in & ~eff_sub;
    end else if (exp_in == '0) begin
      s1_pl_d.ncase = SUBN;
      s1_pl_d.tiny  = ~mant_in[SUM_W-1];
      s1_exp_d      = {{(EXP_W-1){1'b0}}, mant_in[SUM_W-1]};
    end else if (32'(lz) < 32'(exp_in)) begin
      s1_pl_d.ncase = NORM;
      s1_lsh_d      = lz;
      s1_exp_d      = exp_in - EXP_W'(lz);
    end else begin
      // Shift only as far as the minimum exponent allows; the result stays subnormal.
      s1_pl_d.ncase = TINY;
      s1_pl_d.tiny  = 1'b1;
      s1_lsh_d      = LZC_W'(exp_in - EXP_DEC1);
    end
  end

  always_comb begin
    shifted = (s1_pl_q.ncase == CARRY) ? s1_mant_q[SUM_W-1:1]
                                       : (s1_mant_q[SUM_W-2:0] << s1_lsh_q);
    mant_d   = shifted[SUM_W-2 -: MAN_W];
    guard_d  = shifted[STK_W+1];
    round_d  = shifted[STK_W];
    sticky_d = (|shifted[STK_W-1:0]) | s1_pl_q.sticky_lo;
    if (s1_pl_q.ovf) begin
      mant_d   = '0;
      guard_d  = 1'b0;
      round_d  = 1'b0;
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (en1) s1_valid_q <= in_valid;
      if (en2) s2_valid_q <= s1_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_pl_q   <= '0;
      s1_mant_q <= '0;
      s1_exp_q  <= '0;
      s1_lsh_q  <= '0;
    end else if (en1 && in_valid) begin
      s1_pl_q   <= s1_pl_d;
      s1_mant_q <= mant_in;
      s1_exp_q  <= s1_exp_d;
      s1_lsh_q  <= s1_lsh_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      guard_q  <= 1'b0;
      round_q  <= 1'b0;
      sticky_q <= 1'b0;
      zero_q   <= 1'b0;
      tiny_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (en2 && s1_valid_q) begin
      sign_q   <= s1_pl_q.sign;
      exp_q    <= s1_exp_q;
      mant_q   <= mant_d;
      guard_q  <= guard_d;
      round_q  <= round_d;
      sticky_q <= sticky_d;
      zero_q   <= s1_pl_q.zero;
      tiny_q   <= s1_pl_q.tiny;
      ovf_q    <= s1_pl_q.ovf;
    end
  end

  assign out_valid = s2_valid_q;
  assign sign_out  = sign_q;
  assign exp_out   = exp_q;
  assign mant_out  = mant_q;
  assign guard     = guard_q;
  assign round_b   = round_q;
  assign sticky    = sticky_q;
  assign zero_out  = zero_q;
  assign tiny_out  = tiny_q;
  assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// tb/tb_fp_normalize_pipe.sv - self-checking bench for fp_normalize_pipe
module tb_fp_normalize_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign_in = 1'b0;
  logic        eff_sub = 1'b0;
  logic        carry_in = 1'b0;
  logic [47:0] mant_in = '0;
  logic [7:0]  exp_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sign_out;
  logic [7:0]  exp_out;
  logic [22:0] mant_out;
  logic        guard, round_b, sticky, zero_out, tiny_out, ovf_out;

  always #5 clk = ~clk;

  fp_normalize_pipe #(.EXP_W(8), .MAN_W(23), .SUM_W(48)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .eff_sub(eff_sub), .carry_in(carry_in),
    .mant_in(mant_in), .exp_in(exp_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_out(sign_out), .exp_out(exp_out), .mant_out(mant_out),
    .guard(guard), .round_b(round_b), .sticky(sticky),
    .zero_out(zero_out), .tiny_out(tiny_out), .ovf_out(ovf_out)
  );

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic        g, r, st, z, t, o;
  } res_t;

  res_t obs;
  assign obs = {sign_out, exp_out, mant_out, guard, round_b, sticky, zero_out, tiny_out, ovf_out};

  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  res_t sbq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic res_t mk(input logic s, input logic [7:0] e, input logic [22:0] m,
                              input logic g, input logic r, input logic st,
                              input logic z, input logic t, input logic o);
    res_t x;
    x = {s, e, m, g, r, st, z, t, o};
    return x;
  endfunction

  // Treat {carry,mant} as an integer, place its leading one at the hidden position, read fields off.
  function automatic res_t model(input logic c, input logic s, input logic es,
                                 input logic [47:0] m, input logic [7:0] e);
    res_t x;
    longint unsigned v;
    int h, p, lz, ee;
    x = '0;
    x.s = s;
    v = {15'd0, c, m};
    h = 47;
    ee = 0;
    if (c) begin
      ee = int'(e) + 1;
      if (ee >= 255) begin
        x.e = 8'd255;
        x.o = 1'b1;
        return x;
      end
      h = 48;
    end else if (m == 48'd0) begin
      x.z = 1'b1;
      x.s = es ? 1'b0 : s;
      return x;
    end else if (e == 8'd0) begin
      ee = m[47] ? 1 : 0;
      x.t = ~m[47];
    end else begin
      p = 47;
      while (!v[p]) p--;
      lz = 47 - p;
      if (lz < int'(e)) begin
        v = v << lz;
        ee = int'(e) - lz;
      end else begin
        v = v << (int'(e) - 1);
        ee = 0;
        x.t = 1'b1;
      end
    end
    x.e  = 8'(ee);
    x.m  = 23'((v >> (h - 23)) & 64'h7FFFFF);
    x.g  = v[h-24];
    x.r  = v[h-25];
    x.st = (v & ((64'd1 << (h - 25)) - 64'd1)) != 64'd0;
    return x;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
    end else begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          check("sb_spurious", 64'd1, 64'd0);
        end else begin
          check("sb_out", 64'(obs), 64'(sbq[0]));
          if (out_ready) begin
            void'(sbq.pop_front());
            pops++;
          end
        end
      end
      if (in_valid && in_ready && !flush)
        sbq.push_back(model(carry_in, sign_in, eff_sub, mant_in, exp_in));
      if (flush) sbq.delete();
    end
  end

  task automatic set_beat(input logic c, input logic s, input logic es,
                          input logic [47:0] m, input logic [7:0] e);
    carry_in = c;
    sign_in  = s;
    eff_sub  = es;
    mant_in  = m;
    exp_in   = e;
  endtask

  task automatic send(input logic c, input logic s, input logic es,
                      input logic [47:0] m, input logic [7:0] e);
    logic ok;
    @(posedge clk);
    #1;
    set_beat(c, s, es, m, e);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic expect_res(input string tag, input res_t exp);
    int n;
    n = 0;
    for (int i = 1; i <= 6 && n == 0; i++) begin
      @(negedge clk);
      if (out_valid) n = i;
    end
    check({tag, "_lat"}, 64'(n), 64'd2);
    check(tag, 64'(obs), 64'(exp));
  endtask

  task automatic rand_beat();
    logic [47:0] m;
    int mode;
    mode = $urandom_range(0, 9);
    m = {16'($urandom), $urandom};
    if (mode < 4) m = m >> $urandom_range(0, 47);
    else if (mode == 4) m = '0;
    else if (mode == 5) m = 48'd1 << $urandom_range(0, 47);
    set_beat($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), m,
             ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 30))
                                         : 8'($urandom_range(0, 254)));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    res_t e0;
    int   p0;
    logic took;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outputs", 64'(obs), 64'd0);

    out_ready = 1'b1;
    send(1'b1, 1'b0, 1'b0, 48'h800000_000000, 8'd127);
    expect_res("carry", mk(0, 8'd128, 23'h400000, 0, 0, 0, 0, 0, 0));
    send(1'b0, 1'b0, 1'b1, 48'h000001_000000, 8'd100);
    expect_res("cancel", mk(0, 8'd77, 23'h0, 0, 0, 0, 0, 0, 0));
    send(1'b0, 1'b0, 1'b1, 48'h000001_000000, 8'd10);
    expect_res("underflow", mk(0, 8'd0, 23'h000200, 0, 0, 0, 0, 1, 0));
    send(1'b0, 1'b0, 1'b0, 48'h800000_000000, 8'd0);
    expect_res("subn_promo", mk(0, 8'd1, 23'h0, 0, 0, 0, 0, 0, 0));
    send(1'b1, 1'b1, 1'b0, 48'hFFFF_FFFF_FFFF, 8'd254);
    expect_res("overflow", mk(1, 8'd255, 23'h0, 0, 0, 0, 0, 0, 1));
    send(1'b0, 1'b1, 1'b1, 48'h0, 8'd57);
    expect_res("zero", mk(0, 8'd0, 23'h0, 0, 0, 0, 1, 0, 0));
    send(1'b1, 1'b0, 1'b0, 48'h000000_C00001, 8'd50);
    expect_res("carry_grs", mk(0, 8'd51, 23'h0, 0, 1, 1, 0, 0, 0));

    // Three back-to-back beats into a stalled output.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    p0 = pops;
    e0 = model(1'b0, 1'b0, 1'b1, 48'h000001_000000, 8'd10);
    set_beat(1'b0, 1'b0, 1'b1, 48'h000001_000000, 8'd10);
    in_valid = 1'b1;
    @(negedge clk);
    check("bp_rdy0", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    set_beat(1'b1, 1'b1, 1'b0, 48'h800000_000001, 8'd127);
    @(negedge clk);
    check("bp_rdy1", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    set_beat(1'b0, 1'b0, 1'b0, 48'h0000_1234_5678, 8'd200);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_hold_rdy", 64'(in_ready), 64'd0);
      check("bp_hold_out", 64'({out_valid, obs}), 64'({1'b1, e0}));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 10 && pops - p0 < 3; i++) @(negedge clk);
    check("bp_count", 64'(pops - p0), 64'd3);

    // Flush with a full pipeline, then a beat offered during flush.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    set_beat(1'b0, 1'b0, 1'b0, 48'h0F00_0000_0000, 8'd90);
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_drop", 64'(out_valid), 64'd0);
    end

    // Asynchronous reset mid-stream.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #2;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);

    for (int cyc = 0; cyc < 600; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        rand_beat();
        in_valid = 1'b1;
      end
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (took) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
    check("drain_empty", 64'(sbq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
